// File: rtl/dvp_tx_if.sv
// rtl/dvp_tx_if.sv - pixel handshake plus DVP output bus bundle for dvp_tx
interface dvp_tx_if #(
    parameter int DW = 24
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          vsync;
    logic          href;
    logic [7:0]    data;
    logic          frame_done;
    logic          underrun;

    modport master (
        input  in_data, in_valid,
        output in_ready, vsync, href, data, frame_done, underrun
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, vsync, href, data, frame_done, underrun
    );
endinterface

// File: rtl/dvp_tx.sv
// rtl/dvp_tx.sv - DVP transmitter, one byte per pclk, never-stalling line timing
// Optional macro DVP_TX_TEST_PATTERN_EN adds pattern_en ({pixel, line} test pixels).
module dvp_tx #(
    parameter int WIDTH       = 16,
    parameter int HEIGHT      = 16,
    parameter     DATA_FORMAT = "RGB888",
    parameter int VSYNC_LEN   = 4,
    parameter int VBP_LEN     = 8,
    parameter int HBLANK_LEN  = 8,
    parameter int VFP_LEN     = 8
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       en,
`ifdef DVP_TX_TEST_PATTERN_EN
    input  logic       pattern_en,
`endif
    dvp_tx_if.master   bus
);
    localparam int BYTES  = (DATA_FORMAT == "RGB888") ? 3 : 2;
    localparam int DW     = 8 * BYTES;
    localparam int BW     = $clog2(BYTES);
    localparam int PW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int LW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int MAX_A  = (VSYNC_LEN > VBP_LEN) ? VSYNC_LEN : VBP_LEN;
    localparam int MAX_B  = (HBLANK_LEN > VFP_LEN) ? HBLANK_LEN : VFP_LEN;
    localparam int MAXLEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW     = $clog2(MAXLEN + 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBP, LINE, HBLANK, VFP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [LW-1:0] line_q, line_d;
    logic [DW-1:0] sh_q, sh_d;
    logic [7:0]    data_q, data_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic          frame_done_q, frame_done_d;
    logic          underrun_q, underrun_d;
    logic          pix_slot;
    logic          ext_src;
    logic [DW-1:0] pix_word;

`ifdef DVP_TX_TEST_PATTERN_EN
    assign ext_src = !pattern_en;
`else
    assign ext_src = 1'b1;
`endif

    // Cycle before a pixel's first byte: the only point a pixel is taken.
    assign pix_slot = (state_q == VBP && cnt_q == CW'(VBP_LEN - 1)) ||
                      (state_q == HBLANK && cnt_q == CW'(HBLANK_LEN - 1) &&
                       line_q != LW'(HEIGHT - 1)) ||
                      (state_q == LINE && byte_q == BW'(BYTES - 1) &&
                       pix_q != PW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        pix_d   = pix_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = VSYNC;
                    cnt_d   = '0;
                end
            end
            VSYNC: begin
                if (cnt_q == CW'(VSYNC_LEN - 1)) begin
                    state_d = VBP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            VBP: begin
                if (cnt_q == CW'(VBP_LEN - 1)) begin
                    state_d = LINE;
                    cnt_d   = '0;
                    byte_d  = '0;
                    pix_d   = '0;
                    line_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LINE: begin
                if (byte_q == BW'(BYTES - 1)) begin
                    byte_d = '0;
                    if (pix_q == PW'(WIDTH - 1)) begin
                        pix_d   = '0;
                        state_d = HBLANK;
                        cnt_d   = '0;
                    end else begin
                        pix_d = pix_q + 1'b1;
                    end
                end else begin
                    byte_d = byte_q + 1'b1;
                end
            end
            HBLANK: begin
                if (cnt_q == CW'(HBLANK_LEN - 1)) begin
                    cnt_d = '0;
                    if (line_q == LW'(HEIGHT - 1)) begin
                        state_d = VFP;
                        line_d  = '0;
                    end else begin
                        state_d = LINE;
                        line_d  = line_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            VFP: begin
                if (cnt_q == CW'(VFP_LEN - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A missing pixel still occupies its byte slots, as zeros.
        pix_word = bus.in_valid ? bus.in_data : '0;
`ifdef DVP_TX_TEST_PATTERN_EN
        if (pattern_en) pix_word = DW'({pix_d, line_d});
`endif

        sh_d   = sh_q;
        data_d = 8'h00;
        if (pix_slot) begin
            data_d = pix_word[DW-1 -: 8];
            sh_d   = pix_word << 8;
        end else if (state_d == LINE) begin
            data_d = sh_q[DW-1 -: 8];
            sh_d   = sh_q << 8;
        end

        vsync_d      = (state_d == VSYNC);
        href_d       = (state_d == LINE);
        frame_done_d = (state_d == VFP) && (cnt_d == CW'(VFP_LEN - 1));
        underrun_d   = underrun_q | (pix_slot & ext_src & ~bus.in_valid);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            byte_q       <= '0;
            pix_q        <= '0;
            line_q       <= '0;
            sh_q         <= '0;
            data_q       <= 8'h00;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            byte_q       <= byte_d;
            pix_q        <= pix_d;
            line_q       <= line_d;
            sh_q         <= sh_d;
            data_q       <= data_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign bus.in_ready   = pix_slot & ext_src;
    assign bus.vsync      = vsync_q;
    assign bus.href       = href_q;
    assign bus.data       = data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.underrun   = underrun_q;
endmodule

// File: tb/tb_dvp_tx.sv
// tb/tb_dvp_tx.sv - self-checking bench for dvp_tx (RGB565 and RGB888 instances)
module tb_dvp_tx;
    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic rst_a, rst_b, en_a, en_b;
    int   cur;
    int   checks = 0;
    int   errors = 0;

    dvp_tx_if #(.DW(16)) bus_a ();
    dvp_tx_if #(.DW(24)) bus_b ();

    dvp_tx #(.WIDTH(4), .HEIGHT(2), .DATA_FORMAT("RGB565"), .VSYNC_LEN(2),
             .VBP_LEN(2), .HBLANK_LEN(3), .VFP_LEN(2)) dut_a (
        .pclk(pclk), .rst(rst_a), .en(en_a),
`ifdef DVP_TX_TEST_PATTERN_EN
        .pattern_en(1'b0),
`endif
        .bus(bus_a)
    );

    dvp_tx #(.WIDTH(2), .HEIGHT(2), .DATA_FORMAT("RGB888"), .VSYNC_LEN(1),
             .VBP_LEN(1), .HBLANK_LEN(1), .VFP_LEN(1)) dut_b (
        .pclk(pclk), .rst(rst_b), .en(en_b),
`ifdef DVP_TX_TEST_PATTERN_EN
        .pattern_en(1'b0),
`endif
        .bus(bus_b)
    );

    logic       o_vs, o_hr, o_rdy, o_dn, o_und;
    logic [7:0] o_d;
    assign o_vs  = (cur == 1) ? bus_b.vsync      : bus_a.vsync;
    assign o_hr  = (cur == 1) ? bus_b.href       : bus_a.href;
    assign o_rdy = (cur == 1) ? bus_b.in_ready   : bus_a.in_ready;
    assign o_dn  = (cur == 1) ? bus_b.frame_done : bus_a.frame_done;
    assign o_und = (cur == 1) ? bus_b.underrun   : bus_a.underrun;
    assign o_d   = (cur == 1) ? bus_b.data       : bus_a.data;

    int P_W[2]  = '{4, 2};
    int P_H[2]  = '{2, 2};
    int P_B[2]  = '{2, 3};
    int P_VS[2] = '{2, 1};
    int P_VB[2] = '{2, 1};
    int P_HB[2] = '{3, 1};
    int P_VF[2] = '{2, 1};

    typedef struct packed {logic vs; logic hr; logic rdy; logic dn;} exp_t;
    typedef struct {logic [23:0] din; bit valid; logic [7:0] b0; logic [7:0] b1; logic [7:0] b2;} vec_t;
    typedef struct {bit rst; bit en; logic vs; logic hr; logic dn; logic [7:0] d;} rvec_t;

    vec_t       vecs[4];
    rvec_t      rvecs[8];
    logic [7:0] bq[$];
    bit         und_exp[2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int frame_len(input int s);
        return P_VS[s] + P_VB[s] + P_H[s] * (P_W[s] * P_B[s] + P_HB[s]) + P_VF[s];
    endfunction

    // Bus timing at cycle t after vsync rises, from the frame layout alone.
    function automatic exp_t model(input int s, input int t);
        exp_t e;
        int l, u, k;
        e = '0;
        l = P_W[s] * P_B[s] + P_HB[s];
        if (t < P_VS[s]) begin
            e.vs = 1'b1;
        end else if (t < P_VS[s] + P_VB[s]) begin
            e.rdy = (t == P_VS[s] + P_VB[s] - 1);
        end else begin
            u = t - P_VS[s] - P_VB[s];
            if (u < P_H[s] * l) begin
                k = u % l;
                if (k < P_W[s] * P_B[s]) begin
                    e.hr  = 1'b1;
                    e.rdy = (k % P_B[s] == P_B[s] - 1) && (k / P_B[s] != P_W[s] - 1);
                end else begin
                    e.rdy = (k == l - 1) && (u / l != P_H[s] - 1);
                end
            end else begin
                e.dn = (u - P_H[s] * l == P_VF[s] - 1);
            end
        end
        return e;
    endfunction

    task automatic drive(input int s, input bit v, input logic [23:0] d);
        if (s == 0) begin
            bus_a.in_valid = v;
            bus_a.in_data  = d[15:0];
        end else begin
            bus_b.in_valid = v;
            bus_b.in_data  = d;
        end
    endtask

    task automatic set_en(input int s, input bit v);
        if (s == 0) en_a = v; else en_b = v;
    endtask

    task automatic check_bus(input int s, input exp_t e, input logic [7:0] d);
        chk("vsync", int'(o_vs), int'(e.vs));
        chk("href", int'(o_hr), int'(e.hr));
        chk("in_ready", int'(o_rdy), int'(e.rdy));
        chk("frame_done", int'(o_dn), int'(e.dn));
        chk("data", int'(o_d), int'(d));
        chk("underrun", int'(o_und), int'(und_exp[s]));
    endtask

    task automatic idle_chk(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            check_bus(s, '0, 8'h00);
        end
    endtask

    // mode 0: directed pixels (s=0 arithmetic sequence, s=1 vector table); mode 1: random.
    task automatic run_frame(input int s, input int mode, input int bad_pix,
                             input int drop_t, input int rst_t);
        exp_t        e;
        logic [7:0]  exp_d;
        logic [23:0] px;
        bit          v;
        int          pix;
        pix = 0;
        cur = s;
        for (int t = 0; t < frame_len(s); t++) begin
            @(negedge pclk);
            e     = model(s, t);
            exp_d = 8'h00;
            if (e.hr && bq.size() > 0) exp_d = bq.pop_front();
            check_bus(s, e, exp_d);
            if (t == rst_t) begin
                if (s == 0) rst_a = 1'b1; else rst_b = 1'b1;
                bq.delete();
                und_exp[s] = 1'b0;
                drive(s, 1'b0, 24'h0);
                return;
            end
            if (t == drop_t) set_en(s, 1'b0);
            if (e.rdy) begin
                if (mode == 0 && s == 1) begin
                    px = vecs[pix].din;
                    v  = vecs[pix].valid;
                    bq.push_back(vecs[pix].b0);
                    bq.push_back(vecs[pix].b1);
                    bq.push_back(vecs[pix].b2);
                end else begin
                    if (mode == 0) begin
                        px = 24'(16'(16'h1234 + 16'(pix) * 16'h4444));
                        v  = (pix != bad_pix);
                    end else begin
                        px = 24'($urandom);
                        v  = ($urandom_range(0, 7) != 0);
                    end
                    for (int b = P_B[s] - 1; b >= 0; b--)
                        bq.push_back(v ? px[8*b +: 8] : 8'h00);
                end
                if (!v) und_exp[s] = 1'b1;
                pix++;
                drive(s, v, px);
            end else begin
                drive(s, 1'($urandom_range(0, 1)), 24'($urandom));
            end
        end
    endtask

    initial begin
        vecs[0] = '{24'hA1B2C3, 1'b1, 8'hA1, 8'hB2, 8'hC3};
        vecs[1] = '{24'h00FF10, 1'b1, 8'h00, 8'hFF, 8'h10};
        vecs[2] = '{24'h5A5A5A, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{24'hFFFFFF, 1'b1, 8'hFF, 8'hFF, 8'hFF};

        rvecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        rvecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        rvecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        rvecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        rvecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        rvecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        rvecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        rvecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        cur = 0;
        und_exp[0] = 1'b0;
        und_exp[1] = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
        drive(0, 1'b0, 24'h0);
        drive(1, 1'b0, 24'h0);
        repeat (3) @(negedge pclk);

        // Reset / idle / start table on the RGB565 instance.
        for (int i = 0; i < 8; i++) begin
            rst_a = rvecs[i].rst;
            en_a  = rvecs[i].en;
            @(negedge pclk);
            chk($sformatf("rv%0d_vsync", i), int'(o_vs), int'(rvecs[i].vs));
            chk($sformatf("rv%0d_href", i), int'(o_hr), int'(rvecs[i].hr));
            chk($sformatf("rv%0d_ready", i), int'(o_rdy), 0);
            chk($sformatf("rv%0d_done", i), int'(o_dn), int'(rvecs[i].dn));
            chk($sformatf("rv%0d_data", i), int'(o_d), int'(rvecs[i].d));
            chk($sformatf("rv%0d_underrun", i), int'(o_und), 0);
        end

        // Directed frame, back-to-back frame with 3rd-pixel underrun and en dropped in line 1.
        en_a = 1'b1;
        run_frame(0, 0, -1, -1, -1);
        idle_chk(0, 1);
        run_frame(0, 0, 2, 17, -1);
        idle_chk(0, 4);

        // Reset mid-line aborts the frame; restart only through IDLE with en.
        en_a = 1'b1;
        run_frame(0, 0, -1, -1, 9);
        en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check_bus(0, '0, 8'h00);
        end
        rst_a = 1'b0;
        idle_chk(0, 2);
        en_a = 1'b1;
        run_frame(0, 1, -1, -1, -1);
        idle_chk(0, 1);
        run_frame(0, 1, -1, -1, -1);
        idle_chk(0, 1);
        run_frame(0, 1, -1, 3, -1);
        idle_chk(0, 3);

        // RGB888 instance with all blanking lengths at 1.
        cur = 1;
        rst_b = 1'b0;
        idle_chk(1, 2);
        en_b = 1'b1;
        run_frame(1, 0, -1, -1, -1);
        idle_chk(1, 1);
        run_frame(1, 1, -1, 5, -1);
        idle_chk(1, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
